// File: rtl/linear_layer_scheduler.sv
// -----------------------------------------------------------------------------
// linear_layer_scheduler
//
// Sequences one fully-connected layer through the linear MAC processing
// element. For each output group it streams pBEATS input beats from the input
// buffer into the PE. It then pulses pe_done to close the accumulation and
// waits for the PE result strobe before moving on to the next group. After the
// last group it pulses layer_done and returns to idle.
//
// A missing PE result is bounded by a timeout. When the timeout expires, the
// sticky err flag is raised and the layer carries on as if the result had
// arrived, so the layer can never hang.
//
// Ports
//   clk        in   clock
//   rst        in   synchronous, active-high reset
//   start      in   layer start pulse, honoured only in IDLE
//   in_valid   in   input buffer holds the beat addressed by in_addr
//   in_ready   out  scheduler accepts a beat this cycle (RUN only)
//   in_addr    out  beat index within the current group
//   pe_en      out  beat issued to the PE (in_valid && in_ready)
//   pe_done    out  one-cycle pulse closing the group's accumulation
//   pe_valid   in   PE result strobe for the current group
//   out_group  out  index of the group in progress
//   busy       out  high in every state except IDLE
//   layer_done out  one-cycle pulse after the last group's result
//   err        out  sticky protocol/timeout error; cleared by rst or start
// -----------------------------------------------------------------------------
module linear_layer_scheduler #(
    parameter int  pIN_FEATURE      = 6272,
    parameter int  pOUT_FEATURE     = 128,
    parameter int  pCHANNEL         = 32,
    parameter int  pOUTPUT_PARALLEL = 4,
    parameter int  pTIMEOUT         = 64,
    localparam int pBEATS  = pIN_FEATURE / pCHANNEL,
    localparam int pGROUPS = pOUT_FEATURE / pOUTPUT_PARALLEL,
    localparam int AW      = (pBEATS  > 1) ? $clog2(pBEATS)  : 1,
    localparam int GW      = (pGROUPS > 1) ? $clog2(pGROUPS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [AW-1:0] in_addr,
    output logic          pe_en,
    output logic          pe_done,
    input  logic          pe_valid,
    output logic [GW-1:0] out_group,
    output logic          busy,
    output logic          layer_done,
    output logic          err
);

    // The timeout counter only ever holds 0..pTIMEOUT-1. It is sized for
    // pTIMEOUT so that pTIMEOUT == 1 still gives a legal width.
    localparam int TW = $clog2(pTIMEOUT + 1);

    localparam logic [AW-1:0] LAST_BEAT  = AW'(pBEATS - 1);
    localparam logic [GW-1:0] LAST_GROUP = GW'(pGROUPS - 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(pTIMEOUT - 1);

    // -------------------------------------------------------------------------
    // Parameter sanity: the layer must split into whole beats and whole groups.
    // -------------------------------------------------------------------------
    generate
        if ((pIN_FEATURE % pCHANNEL) != 0) begin : g_bad_beats
            $error("pIN_FEATURE must be an exact multiple of pCHANNEL");
        end
        if ((pOUT_FEATURE % pOUTPUT_PARALLEL) != 0) begin : g_bad_groups
            $error("pOUT_FEATURE must be an exact multiple of pOUTPUT_PARALLEL");
        end
        if (pTIMEOUT < 1) begin : g_bad_timeout
            $error("pTIMEOUT must be at least 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_CLOSE,
        S_WAIT,
        S_FIN
    } state_t;

    state_t        state_q,     state_d;
    logic [AW-1:0] in_addr_q,   in_addr_d;
    logic [GW-1:0] out_group_q, out_group_d;
    logic [TW-1:0] tmo_q,       tmo_d;
    logic          err_q,       err_d;

    logic handshake;
    logic tmo_hit;

    // A beat is transferred only while RUN presents in_ready.
    assign handshake = in_valid && (state_q == S_RUN);

    // This is the last WAIT cycle before the counter would reach pTIMEOUT.
    // A result strobe arriving in this same cycle still counts as on time.
    assign tmo_hit = (tmo_q == TMO_LAST);

    // -------------------------------------------------------------------------
    // State and counter registers
    // -------------------------------------------------------------------------
    // NOTE: reset is sampled on the clock edge only (synchronous), and every
    // register here uses non-blocking assignment so that all of them update
    // together from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            in_addr_q   <= '0;
            out_group_q <= '0;
            tmo_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_addr_q   <= in_addr_d;
            out_group_q <= out_group_d;
            tmo_q       <= tmo_d;
            err_q       <= err_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and counter update
    // -------------------------------------------------------------------------
    // NOTE: every value computed here is given its hold value first, so no
    // path through the case statement can leave one unassigned and infer a
    // latch.
    always_comb begin
        state_d     = state_q;
        in_addr_d   = in_addr_q;
        out_group_d = out_group_q;
        tmo_d       = tmo_q;
        err_d       = err_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    // An accepted start opens a fresh layer and clears any
                    // error left over from the previous one.
                    state_d     = S_RUN;
                    in_addr_d   = '0;
                    out_group_d = '0;
                    tmo_d       = '0;
                    err_d       = 1'b0;
                end else if (pe_valid) begin
                    err_d = 1'b1;
                end
            end

            S_RUN: begin
                if (pe_valid) begin
                    err_d = 1'b1;
                end
                if (handshake) begin
                    if (in_addr_q == LAST_BEAT) begin
                        in_addr_d = '0;
                        state_d   = S_CLOSE;
                    end else begin
                        in_addr_d = in_addr_q + AW'(1);
                    end
                end
            end

            S_CLOSE: begin
                // No result can be legitimate before pe_done has been seen.
                if (pe_valid) begin
                    err_d = 1'b1;
                end
                state_d = S_WAIT;
            end

            S_WAIT: begin
                if (pe_valid || tmo_hit) begin
                    // A timeout is flagged but handled exactly like a result,
                    // so the layer always completes.
                    if (!pe_valid) begin
                        err_d = 1'b1;
                    end
                    tmo_d = '0;
                    if (out_group_q == LAST_GROUP) begin
                        state_d = S_FIN;
                    end else begin
                        out_group_d = out_group_q + GW'(1);
                        state_d     = S_RUN;
                    end
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end

            S_FIN: begin
                out_group_d = '0;
                state_d     = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs: decodes of registered state. pe_en is the one combinational
    // path, so that a beat is issued in the same cycle the buffer offers it.
    // -------------------------------------------------------------------------
    assign in_ready   = (state_q == S_RUN);
    assign pe_en      = in_valid && in_ready;
    assign pe_done    = (state_q == S_CLOSE);
    assign busy       = (state_q != S_IDLE);
    assign layer_done = (state_q == S_FIN);
    assign in_addr    = in_addr_q;
    assign out_group  = out_group_q;
    assign err        = err_q;

endmodule

// File: tb/tb_linear_layer_scheduler.sv
// -----------------------------------------------------------------------------
// tb_linear_layer_scheduler
//
// Directed bench for linear_layer_scheduler at its default geometry: 196 beats
// per group, 32 groups, and a timeout of 64.
//
// Inputs are driven 1 time unit after the rising edge. Outputs are sampled on
// the falling edge.
//
// A PE model answers each pe_done with a one-cycle pe_valid 12 cycles later,
// except for the group named by withhold_grp.
//
// A monitor counts pe_en, pe_done and layer_done pulses. It also tracks the
// expected beat index and group index, independently of the design.
// -----------------------------------------------------------------------------
module tb_linear_layer_scheduler;

    localparam int BEATS  = 196;
    localparam int GROUPS = 32;
    localparam int PE_LAT = 12;
    localparam int BUDGET = 16000;

    logic       clk;
    logic       rst;
    logic       start;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_addr;
    logic       pe_en;
    logic       pe_done;
    logic       pe_valid;
    logic [4:0] out_group;
    logic       busy;
    logic       layer_done;
    logic       err;

    logic pe_model_valid;
    logic pe_force;
    int   withhold_grp;

    int checks = 0;
    int passes = 0;

    // Monitor totals (written only by the monitor)
    int en_total    = 0;
    int done_total  = 0;
    int ldone_total = 0;
    int addr_err    = 0;
    int grp_err     = 0;
    int done_err    = 0;
    int en_err      = 0;
    int mon_beat    = 0;
    int mon_grp     = 0;

    // Snapshots taken at the start of a scenario
    int s_en, s_done, s_ldone, s_addr, s_grp, s_dn, s_enx;

    assign pe_valid = pe_model_valid | pe_force;

    linear_layer_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_addr    (in_addr),
        .pe_en      (pe_en),
        .pe_done    (pe_done),
        .pe_valid   (pe_valid),
        .out_group  (out_group),
        .busy       (busy),
        .layer_done (layer_done),
        .err        (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // PE model: pe_valid is high for one cycle, PE_LAT cycles after the
    // pe_done cycle.
    initial begin : pe_model
        int countdown;
        countdown      = 0;
        pe_model_valid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            pe_model_valid = 1'b0;
            if (busy !== 1'b1) begin
                countdown = 0;
            end else begin
                if (countdown > 0) begin
                    countdown--;
                    if (countdown == 0) pe_model_valid = 1'b1;
                end
                if (pe_done === 1'b1 && int'(out_group) != withhold_grp) countdown = PE_LAT;
            end
        end
    end

    // Monitor: counts pulses and checks the beat and group sequences.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            mon_beat = 0;
            mon_grp  = 0;
        end else begin
            if (pe_en !== (in_valid && in_ready)) en_err++;
            if (pe_en === 1'b1) begin
                en_total++;
                if (int'(in_addr) != mon_beat) addr_err++;
                if (int'(out_group) != mon_grp) grp_err++;
                mon_beat++;
            end
            if (pe_done === 1'b1) begin
                done_total++;
                if (mon_beat != BEATS) done_err++;
                mon_beat = 0;
                mon_grp++;
            end
            if (layer_done === 1'b1) begin
                ldone_total++;
                if (mon_grp != GROUPS) grp_err++;
                mon_grp = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        s_en = en_total; s_done = done_total; s_ldone = ldone_total;
        s_addr = addr_err; s_grp = grp_err; s_dn = done_err; s_enx = en_err;
    endtask

    task automatic drive_until_done(input bit rnd, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            step();
            in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (layer_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_until_beat(input int g, input int a, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            step();
            in_valid = 1'b1;
            @(negedge clk);
            if (in_ready === 1'b1 && int'(out_group) == g && int'(in_addr) == a) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_until_close(input int g, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            step();
            in_valid = 1'b1;
            @(negedge clk);
            if (pe_done === 1'b1 && int'(out_group) == g) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b1; pe_force = 1'b0;
        step(); step();
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got=%0b exp=0", in_ready); else passes++;
        checks++; if (in_addr !== 8'd0) $display("FAIL reset_in_addr got=%0d exp=0", in_addr); else passes++;
        checks++; if (pe_en !== 1'b0) $display("FAIL reset_pe_en got=%0b exp=0", pe_en); else passes++;
        checks++; if (pe_done !== 1'b0) $display("FAIL reset_pe_done got=%0b exp=0", pe_done); else passes++;
        checks++; if (out_group !== 5'd0) $display("FAIL reset_out_group got=%0d exp=0", out_group); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%0b exp=0", busy); else passes++;
        checks++; if (layer_done !== 1'b0) $display("FAIL reset_layer_done got=%0b exp=0", layer_done); else passes++;
        checks++; if (err !== 1'b0) $display("FAIL reset_err got=%0b exp=0", err); else passes++;
        step();
        rst = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_nominal();
        bit seen;
        step(); snap(); start = 1'b1; in_valid = 1'b1;          // cycle t
        step(); start = 1'b0;                                   // t+1
        @(negedge clk);
        checks++; if (busy !== 1'b1) $display("FAIL nom_busy_t1 got=%0b exp=1", busy); else passes++;
        checks++; if (in_ready !== 1'b1) $display("FAIL nom_ready_t1 got=%0b exp=1", in_ready); else passes++;
        checks++; if (in_addr !== 8'd0) $display("FAIL nom_addr_t1 got=%0d exp=0", in_addr); else passes++;
        checks++; if (pe_en !== 1'b1) $display("FAIL nom_pe_en_t1 got=%0b exp=1", pe_en); else passes++;
        repeat (195) step();                                    // t+196
        @(negedge clk);
        checks++; if (in_addr !== 8'd195) $display("FAIL nom_addr_t196 got=%0d exp=195", in_addr); else passes++;
        checks++; if (pe_done !== 1'b0) $display("FAIL nom_early_done got=%0b exp=0", pe_done); else passes++;
        step(); @(negedge clk);                                 // t+197 CLOSE
        checks++; if (pe_done !== 1'b1) $display("FAIL nom_done_t197 got=%0b exp=1", pe_done); else passes++;
        checks++; if (pe_en !== 1'b0) $display("FAIL nom_pe_en_close got=%0b exp=0", pe_en); else passes++;
        step(); @(negedge clk);                                 // t+198 WAIT
        checks++; if (pe_done !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0)
            $display("FAIL nom_wait_t198 got done=%0b busy=%0b ready=%0b exp 0/1/0", pe_done, busy, in_ready);
        else passes++;
        repeat (12) step(); @(negedge clk);                     // t+210 RUN group 1
        checks++; if (in_ready !== 1'b1 || out_group !== 5'd1 || in_addr !== 8'd0)
            $display("FAIL nom_restart got ready=%0b grp=%0d addr=%0d exp 1/1/0", in_ready, out_group, in_addr);
        else passes++;
        drive_until_done(1'b0, seen);
        checks++; if (seen !== 1'b1) $display("FAIL nom_layer_done got=%0b exp=1", seen); else passes++;
        step(); @(negedge clk);
        checks++; if (busy !== 1'b0 || out_group !== 5'd0 || err !== 1'b0)
            $display("FAIL nom_idle got busy=%0b grp=%0d err=%0b exp 0/0/0", busy, out_group, err);
        else passes++;
        step(); in_valid = 1'b0;
        checks++; if (en_total - s_en !== 6272) $display("FAIL nom_pe_en_count got=%0d exp=6272", en_total - s_en); else passes++;
        checks++; if (done_total - s_done !== 32) $display("FAIL nom_done_count got=%0d exp=32", done_total - s_done); else passes++;
        checks++; if (ldone_total - s_ldone !== 1) $display("FAIL nom_ldone_count got=%0d exp=1", ldone_total - s_ldone); else passes++;
        checks++; if (addr_err - s_addr !== 0 || grp_err - s_grp !== 0)
            $display("FAIL nom_sequence got addr_err=%0d grp_err=%0d exp 0", addr_err - s_addr, grp_err - s_grp);
        else passes++;
    endtask

    task automatic test_stall();
        bit seen;
        step(); snap(); start = 1'b1; in_valid = 1'b0;
        step(); start = 1'b0; in_valid = 1'($urandom_range(0, 1));
        drive_until_done(1'b1, seen);
        checks++; if (seen !== 1'b1) $display("FAIL stall_layer_done got=%0b exp=1", seen); else passes++;
        step(); in_valid = 1'b0;
        checks++; if (en_total - s_en !== 6272) $display("FAIL stall_pe_en_count got=%0d exp=6272", en_total - s_en); else passes++;
        checks++; if (addr_err - s_addr !== 0) $display("FAIL stall_addr_seq got=%0d exp=0", addr_err - s_addr); else passes++;
        checks++; if (done_err - s_dn !== 0 || done_total - s_done !== 32)
            $display("FAIL stall_done got bad=%0d count=%0d exp 0/32", done_err - s_dn, done_total - s_done);
        else passes++;
        checks++; if (en_err - s_enx !== 0) $display("FAIL stall_pe_en_comb got=%0d exp=0", en_err - s_enx); else passes++;
        checks++; if (err !== 1'b0) $display("FAIL stall_err got=%0b exp=0", err); else passes++;
    endtask

    task automatic test_timeout();
        bit ok;
        bit seen;
        withhold_grp = 5;
        step(); snap(); start = 1'b1; in_valid = 1'b1;
        step(); start = 1'b0;
        run_until_close(5, ok);                                 // cycle c
        checks++; if (ok !== 1'b1) $display("FAIL tmo_reach_grp5 got=%0b exp=1", ok); else passes++;
        repeat (64) step(); @(negedge clk);                     // c+64: last WAIT cycle
        checks++; if (err !== 1'b0 || out_group !== 5'd5 || in_ready !== 1'b0)
            $display("FAIL tmo_before got err=%0b grp=%0d ready=%0b exp 0/5/0", err, out_group, in_ready);
        else passes++;
        step(); @(negedge clk);                                 // c+65
        checks++; if (err !== 1'b1 || out_group !== 5'd6 || in_ready !== 1'b1)
            $display("FAIL tmo_after got err=%0b grp=%0d ready=%0b exp 1/6/1", err, out_group, in_ready);
        else passes++;
        withhold_grp = -1;
        drive_until_done(1'b0, seen);
        checks++; if (seen !== 1'b1 || err !== 1'b1)
            $display("FAIL tmo_finish got done=%0b err=%0b exp 1/1", seen, err);
        else passes++;
        step(); in_valid = 1'b0;
        checks++; if (done_total - s_done !== 32 || ldone_total - s_ldone !== 1)
            $display("FAIL tmo_counts got done=%0d ldone=%0d exp 32/1", done_total - s_done, ldone_total - s_ldone);
        else passes++;
    endtask

    task automatic test_spurious();
        bit ok;
        step(); start = 1'b1; in_valid = 1'b1;
        step(); start = 1'b0; @(negedge clk);
        checks++; if (err !== 1'b0) $display("FAIL spur_start_clears got=%0b exp=0", err); else passes++;
        run_until_beat(0, 20, ok);
        checks++; if (ok !== 1'b1) $display("FAIL spur_reach_beat got=%0b exp=1", ok); else passes++;
        step(); pe_force = 1'b1;                                // beat 21 with spurious result
        step(); pe_force = 1'b0; @(negedge clk);
        checks++; if (err !== 1'b1 || in_addr !== 8'd22 || out_group !== 5'd0 || in_ready !== 1'b1)
            $display("FAIL spur_run got err=%0b addr=%0d grp=%0d ready=%0b exp 1/22/0/1", err, in_addr, out_group, in_ready);
        else passes++;
        step(); rst = 1'b1; in_valid = 1'b0;
        step(); rst = 1'b0;
        step(); pe_force = 1'b1;                                // spurious result in IDLE
        step(); pe_force = 1'b0; @(negedge clk);
        checks++; if (err !== 1'b1 || busy !== 1'b0 || in_addr !== 8'd0 || out_group !== 5'd0)
            $display("FAIL spur_idle got err=%0b busy=%0b addr=%0d grp=%0d exp 1/0/0/0", err, busy, in_addr, out_group);
        else passes++;
        step(); start = 1'b1;
        step(); start = 1'b0; @(negedge clk);
        checks++; if (err !== 1'b0 || busy !== 1'b1)
            $display("FAIL spur_restart got err=%0b busy=%0b exp 0/1", err, busy);
        else passes++;
        step(); rst = 1'b1;
        step(); rst = 1'b0;
    endtask

    task automatic test_mid_reset();
        bit ok;
        bit seen;
        step(); start = 1'b1; in_valid = 1'b1;
        step(); start = 1'b0;
        run_until_beat(10, 100, ok);
        checks++; if (ok !== 1'b1) $display("FAIL mrst_reach got=%0b exp=1", ok); else passes++;
        step(); rst = 1'b1;
        step(); rst = 1'b0; @(negedge clk);                     // in_valid still 1
        checks++; if (in_ready !== 1'b0 || in_addr !== 8'd0 || pe_en !== 1'b0 || pe_done !== 1'b0 ||
                      out_group !== 5'd0 || busy !== 1'b0 || layer_done !== 1'b0 || err !== 1'b0)
            $display("FAIL mrst_outputs got ready=%0b addr=%0d en=%0b done=%0b grp=%0d busy=%0b ldone=%0b err=%0b exp all 0",
                     in_ready, in_addr, pe_en, pe_done, out_group, busy, layer_done, err);
        else passes++;
        step(); snap(); start = 1'b1;
        step(); start = 1'b0;
        drive_until_done(1'b0, seen);
        checks++; if (seen !== 1'b1) $display("FAIL mrst_layer_done got=%0b exp=1", seen); else passes++;
        step(); in_valid = 1'b0;
        checks++; if (en_total - s_en !== 6272 || done_total - s_done !== 32 || ldone_total - s_ldone !== 1)
            $display("FAIL mrst_counts got en=%0d done=%0d ldone=%0d exp 6272/32/1",
                     en_total - s_en, done_total - s_done, ldone_total - s_ldone);
        else passes++;
        checks++; if (addr_err - s_addr !== 0 || grp_err - s_grp !== 0 || err !== 1'b0)
            $display("FAIL mrst_sequence got addr_err=%0d grp_err=%0d err=%0b exp 0/0/0", addr_err - s_addr, grp_err - s_grp, err);
        else passes++;
    endtask

    task automatic test_back_to_back();
        bit ok;
        bit seen;
        step(); snap(); start = 1'b1; in_valid = 1'b1;
        step(); start = 1'b0;
        run_until_beat(0, 50, ok);
        checks++; if (ok !== 1'b1) $display("FAIL b2b_reach got=%0b exp=1", ok); else passes++;
        step(); start = 1'b1; @(negedge clk);                   // start pulse during RUN
        step(); start = 1'b0; @(negedge clk);
        checks++; if (in_addr !== 8'd52 || out_group !== 5'd0 || in_ready !== 1'b1)
            $display("FAIL b2b_run_start got addr=%0d grp=%0d ready=%0b exp 52/0/1", in_addr, out_group, in_ready);
        else passes++;
        run_until_close(0, ok);
        checks++; if (ok !== 1'b1) $display("FAIL b2b_close got=%0b exp=1", ok); else passes++;
        step(); start = 1'b1;                                   // start pulse during WAIT
        step(); start = 1'b0; @(negedge clk);
        checks++; if (in_ready !== 1'b0 || busy !== 1'b1 || out_group !== 5'd0)
            $display("FAIL b2b_wait_start got ready=%0b busy=%0b grp=%0d exp 0/1/0", in_ready, busy, out_group);
        else passes++;
        drive_until_done(1'b0, seen);                           // FIN cycle f
        checks++; if (seen !== 1'b1) $display("FAIL b2b_first_done got=%0b exp=1", seen); else passes++;
        step(); start = 1'b1; @(negedge clk);                   // f+1: IDLE gap
        checks++; if (busy !== 1'b0) $display("FAIL b2b_gap got busy=%0b exp=0", busy); else passes++;
        step(); start = 1'b0; @(negedge clk);                   // f+2: second layer RUN
        checks++; if (busy !== 1'b1 || in_ready !== 1'b1 || in_addr !== 8'd0 || out_group !== 5'd0)
            $display("FAIL b2b_second_start got busy=%0b ready=%0b addr=%0d grp=%0d exp 1/1/0/0", busy, in_ready, in_addr, out_group);
        else passes++;
        drive_until_done(1'b0, seen);
        checks++; if (seen !== 1'b1) $display("FAIL b2b_second_done got=%0b exp=1", seen); else passes++;
        step(); in_valid = 1'b0;
        checks++; if (en_total - s_en !== 12544 || done_total - s_done !== 64 || ldone_total - s_ldone !== 2)
            $display("FAIL b2b_counts got en=%0d done=%0d ldone=%0d exp 12544/64/2",
                     en_total - s_en, done_total - s_done, ldone_total - s_ldone);
        else passes++;
        checks++; if (addr_err - s_addr !== 0 || grp_err - s_grp !== 0 || en_err - s_enx !== 0)
            $display("FAIL b2b_sequence got addr_err=%0d grp_err=%0d en_err=%0d exp 0",
                     addr_err - s_addr, grp_err - s_grp, en_err - s_enx);
        else passes++;
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        in_valid     = 1'b0;
        pe_force     = 1'b0;
        withhold_grp = -1;
        test_reset();
        test_nominal();
        test_stall();
        test_timeout();
        test_spurious();
        test_mid_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/linear_layer_scheduler.md
# linear_layer_scheduler

Sequences one fully-connected layer through the linear MAC processing element. It streams `pIN_FEATURE/pCHANNEL` input beats per output group, then pulses `pe_done` to close the accumulation. It waits for the PE result strobe and repeats for all `pOUT_FEATURE/pOUTPUT_PARALLEL` groups. It sits between the layer-level control/input buffer and the PE controller, and reports completion and protocol errors upward.

## Interface
Parameters:
- `pIN_FEATURE`, 6272: input features per output neuron.
- `pOUT_FEATURE`, 128: output neurons in the layer.
- `pCHANNEL`, 32: input features consumed per beat.
- `pOUTPUT_PARALLEL`, 4: output neurons computed per group.
- `pTIMEOUT`, 64: maximum number of cycles from `pe_done` to `pe_valid`.
- Derived: `pBEATS = pIN_FEATURE/pCHANNEL` (196) and `pGROUPS = pOUT_FEATURE/pOUTPUT_PARALLEL` (32).
- Both divisions are exact; a non-exact division is an elaboration error.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `start`, in, 1: layer start pulse; sampled only in IDLE.
- `in_valid`, in, 1: input buffer has the beat at `in_addr`.
- `in_ready`, out, 1: scheduler accepts a beat this cycle.
- `in_addr`, out, `$clog2(pBEATS)`: beat index within the current group.
- `pe_en`, out, 1: beat issued to the PE; equals `in_valid && in_ready`.
- `pe_done`, out, 1: one-cycle pulse closing the group's accumulation.
- `pe_valid`, in, 1: PE result strobe for the current group.
- `out_group`, out, `$clog2(pGROUPS)`: index of the group in progress.
- `busy`, out, 1: high in every state except IDLE.
- `layer_done`, out, 1: one-cycle pulse after the last group's result.
- `err`, out, 1: sticky error flag; cleared only by `rst` or by an accepted `start`.

## Operation
States: IDLE, RUN, CLOSE, WAIT, FIN.

- **IDLE**
  - `start`=1 moves to RUN; `in_addr`, `out_group` and the timeout counter clear to 0, and `err` clears.
  - `pe_valid`=1 while in IDLE sets `err`.
- **RUN**
  - `in_ready`=1.
  - Each handshake (`in_valid && in_ready`) asserts `pe_en` and increments `in_addr`.
  - The handshake at `in_addr==pBEATS-1` moves to CLOSE, and `in_addr` wraps to 0.
  - `in_valid`=0 stalls: `pe_en`=0 and nothing advances. Stalls are unbounded.
- **CLOSE**
  - `pe_done`=1 for exactly this one cycle; `in_ready`=0.
  - Always moves to WAIT.
- **WAIT**
  - `in_ready`=0. The timeout counter increments each cycle.
  - `pe_valid`=1 with `out_group<pGROUPS-1`: `out_group` increments, the timeout counter clears, and the state moves to RUN.
  - `pe_valid`=1 with `out_group==pGROUPS-1`: move to FIN.
  - Timeout counter reaches `pTIMEOUT`: set `err`, then continue as if `pe_valid` had arrived (advance or FIN) so the layer cannot hang.
- **FIN**
  - `layer_done`=1 for one cycle; `out_group` wraps to 0.
  - Always moves to IDLE.

General rules:
- `pe_valid` in RUN or CLOSE sets `err` and is otherwise ignored.
- `start` outside IDLE is ignored and has no effect.
- Counters are unsigned. `in_addr` wraps only at `pBEATS-1`, and `out_group` only at `pGROUPS-1`.

## Timing
- Reset values: state IDLE, and all outputs 0 (`in_ready`, `in_addr`, `pe_en`, `pe_done`, `out_group`, `busy`, `layer_done`, `err`).
- All outputs are registered-state decodes. The exception is `pe_en`, which is combinational from `in_valid` and the state.
- `start` in cycle t: `busy` and `in_ready` are high from t+1.
- With `in_valid` held at 1, beats issue in t+1..t+196, `pe_done` is high at t+197, and WAIT begins at t+198.
- `pe_valid` at cycle w: the next group's RUN starts at w+1 (zero-bubble restart), or FIN is at w+1 for the last group. `layer_done` is at w+1, and IDLE with `busy`=0 is at w+2.
- `rst` asserted in any state: return to IDLE next cycle with reset values. Partial progress is discarded and no `pe_done` or `layer_done` is emitted.
- `start` is accepted the same cycle IDLE is re-entered after FIN; back-to-back layers therefore have a 1-cycle IDLE bubble.

## Test plan
- **Nominal layer.** `start`, `in_valid`=1 constant, PE model returns `pe_valid` 12 cycles after each `pe_done`.
  - Required: 32×196 `pe_en` pulses and 32 `pe_done` pulses.
  - Required: `in_addr` sequence 0..195 per group, `out_group` 0..31.
  - Required: exactly one `layer_done`, `err`=0.
- **Random stall.** `in_valid` driven 50% random.
  - Required: `pe_en` count still 196 per group, no `in_addr` skip or repeat.
  - Required: `pe_done` only after beat 195.
- **Timeout.** PE model withholds `pe_valid` for group 5.
  - Required: `err` rises `pTIMEOUT` cycles into WAIT, `out_group` advances to 6.
  - Required: layer completes with `layer_done`=1 and `err` still 1.
- **Spurious result.** `pe_valid` pulsed in IDLE and in RUN.
  - Required: `err`=1; `in_addr`/`out_group` unaffected.
  - Required: next `start` clears `err`.
- **Mid-layer reset.** `rst` asserted at group 10, beat 100.
  - Required: next cycle all outputs 0 and state IDLE.
  - Required: a fresh `start` runs the full 32 groups correctly.
- **Ignored start and back-to-back layers.** `start` pulsed during RUN and WAIT, then again in the FIN-to-IDLE cycle.
  - Required: no state or counter disturbance from the mid-layer pulses.
  - Required: second layer begins with a 1-cycle IDLE gap.
